// File: rtl/vga_timing_generator.sv
// ----------------------------------------------------------------------------
// vga_timing_generator
//
// Purpose:
//   Free-running VGA raster timing source for the ball/paddle renderers.
//   From a single pixel clock it produces hsync/vsync, blanking, a visible
//   flag, the current pixel coordinates, line/frame start strobes and a
//   frame counter for per-frame animation.  Every output is a register
//   loaded from a decode of the next raster position, so all outputs in a
//   given cycle describe the same pixel.
//
// Ports:
//   i_clk          pixel clock
//   i_rst_n        asynchronous active-low reset
//   o_hsync        horizontal sync, active level = SYNC_POL
//   o_vsync        vertical sync, active level = SYNC_POL (whole-line decode)
//   o_hblank       1 when o_hpos >= H_VISIBLE
//   o_vblank       1 when o_vpos >= V_VISIBLE
//   o_visible      1 inside the active picture area
//   o_hpos         pixel column, 0..H_TOTAL-1
//   o_vpos         line number, 0..V_TOTAL-1
//   o_line_start   one-cycle strobe at o_hpos == 0
//   o_frame_start  one-cycle strobe at (o_hpos, o_vpos) == (0, 0)
//   o_frame_count  frames completed since reset, wraps modulo 2^FRAME_W
// ----------------------------------------------------------------------------
module vga_timing_generator #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   FRAME_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_hblank,
    output logic               o_vblank,
    output logic               o_visible,
    output logic [9:0]         o_hpos,
    output logic [9:0]         o_vpos,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [FRAME_W-1:0] o_frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // ST_IDLE holds for exactly the first edge after reset release: that edge
    // presents pixel (0,0) instead of advancing, so the raster starts cleanly.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [9:0]         hPos_q, hPos_d;
    logic [9:0]         vPos_q, vPos_d;
    logic [FRAME_W-1:0] frameCount_q, frameCount_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               hblank_q, hblank_d;
    logic               vblank_q, vblank_d;
    logic               visible_q, visible_d;
    logic               lineStart_q, lineStart_d;
    logic               frameStart_q, frameStart_d;

    // Next raster position.  The frame counter steps only on a real wrap from
    // the last pixel of a frame, never on the post-reset (0,0) presentation.
    always_comb begin
        hPos_d       = hPos_q;
        vPos_d       = vPos_q;
        frameCount_d = frameCount_q;
        if (state_q == ST_IDLE) begin
            hPos_d       = '0;
            vPos_d       = '0;
            frameCount_d = '0;
        end else if (hPos_q == H_LAST) begin
            hPos_d = '0;
            if (vPos_q == V_LAST) begin
                vPos_d       = '0;
                frameCount_d = frameCount_q + FRAME_W'(1);
            end else begin
                vPos_d = vPos_q + 10'd1;
            end
        end else begin
            hPos_d = hPos_q + 10'd1;
        end
    end

    // Decode everything from the next position so the registered flags line
    // up with the registered coordinates.
    always_comb begin
        hblank_d     = (hPos_d >= H_VIS);
        vblank_d     = (vPos_d >= V_VIS);
        visible_d    = ~hblank_d & ~vblank_d;
        hsync_d      = ((hPos_d >= HS_FIRST) && (hPos_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_d      = ((vPos_d >= VS_FIRST) && (vPos_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        lineStart_d  = (hPos_d == 10'd0);
        frameStart_d = (hPos_d == 10'd0) && (vPos_d == 10'd0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            hPos_q       <= '0;
            vPos_q       <= '0;
            frameCount_q <= '0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            hblank_q     <= 1'b0;
            vblank_q     <= 1'b0;
            visible_q    <= 1'b0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            state_q      <= ST_RUN;
            hPos_q       <= hPos_d;
            vPos_q       <= vPos_d;
            frameCount_q <= frameCount_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            hblank_q     <= hblank_d;
            vblank_q     <= vblank_d;
            visible_q    <= visible_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_hblank      = hblank_q;
    assign o_vblank      = vblank_q;
    assign o_visible     = visible_q;
    assign o_hpos        = hPos_q;
    assign o_vpos        = vPos_q;
    assign o_line_start  = lineStart_q;
    assign o_frame_start = frameStart_q;
    assign o_frame_count = frameCount_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
module tb_vga_timing_generator;

    // Two small rasters keep full frames short; B uses active-high syncs.
    localparam int A_HV = 16, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VV = 12, A_VF = 2, A_VS = 2, A_VB = 3;
    localparam int A_FW = 2;
    localparam int A_FT = (A_HV + A_HF + A_HS + A_HB) * (A_VV + A_VF + A_VS + A_VB);

    localparam int B_HV = 20, B_HF = 3, B_HS = 4, B_HB = 5;
    localparam int B_VV = 10, B_VF = 1, B_VS = 3, B_VB = 2;
    localparam int B_FW = 8;

    typedef struct packed {
        int hsync;
        int vsync;
        int hblank;
        int vblank;
        int visible;
        int hpos;
        int vpos;
        int lineStart;
        int frameStart;
        int frameCount;
    } sigT;

    logic clk;
    logic rstN;

    logic aHsync, aVsync, aHblank, aVblank, aVisible, aLineStart, aFrameStart;
    logic [9:0] aHpos, aVpos;
    logic [A_FW-1:0] aFrameCount;
    logic bHsync, bVsync, bHblank, bVblank, bVisible, bLineStart, bFrameStart;
    logic [9:0] bHpos, bVpos;
    logic [B_FW-1:0] bFrameCount;

    int compared = 0;
    int mismatched = 0;
    int t = 0;
    int visibleCount = 0;

    sigT obsA, obsB;

    vga_timing_generator #(
        .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .SYNC_POL(1'b0), .FRAME_W(A_FW)
    ) dutA (
        .i_clk(clk), .i_rst_n(rstN),
        .o_hsync(aHsync), .o_vsync(aVsync), .o_hblank(aHblank), .o_vblank(aVblank),
        .o_visible(aVisible), .o_hpos(aHpos), .o_vpos(aVpos),
        .o_line_start(aLineStart), .o_frame_start(aFrameStart),
        .o_frame_count(aFrameCount)
    );

    vga_timing_generator #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .SYNC_POL(1'b1), .FRAME_W(B_FW)
    ) dutB (
        .i_clk(clk), .i_rst_n(rstN),
        .o_hsync(bHsync), .o_vsync(bVsync), .o_hblank(bHblank), .o_vblank(bVblank),
        .o_visible(bVisible), .o_hpos(bHpos), .o_vpos(bVpos),
        .o_line_start(bLineStart), .o_frame_start(bFrameStart),
        .o_frame_count(bFrameCount)
    );

    // Pixel clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bundle each DUT's outputs for field-by-field comparison
    always_comb begin
        obsA = '{hsync: int'(aHsync), vsync: int'(aVsync), hblank: int'(aHblank),
                 vblank: int'(aVblank), visible: int'(aVisible), hpos: int'(aHpos),
                 vpos: int'(aVpos), lineStart: int'(aLineStart),
                 frameStart: int'(aFrameStart), frameCount: int'(aFrameCount)};
        obsB = '{hsync: int'(bHsync), vsync: int'(bVsync), hblank: int'(bHblank),
                 vblank: int'(bVblank), visible: int'(bVisible), hpos: int'(bHpos),
                 vpos: int'(bVpos), lineStart: int'(bLineStart),
                 frameStart: int'(bFrameStart), frameCount: int'(bFrameCount)};
    end

    // Expected raster state t cycles after the first post-release edge:
    // the raster is just a linear pixel index folded into lines and frames.
    function automatic sigT modelAt(input int cyc, input int hv, input int hf,
                                    input int hs, input int hb, input int vv,
                                    input int vf, input int vs, input int vb,
                                    input int pol, input int fw);
        sigT e;
        int ht, vt, ft, p, h, v;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        ft = ht * vt;
        p  = cyc % ft;
        h  = p % ht;
        v  = p / ht;
        e.hpos       = h;
        e.vpos       = v;
        e.hblank     = (h >= hv) ? 1 : 0;
        e.vblank     = (v >= vv) ? 1 : 0;
        e.visible    = (h < hv && v < vv) ? 1 : 0;
        e.hsync      = (h >= hv + hf && h < hv + hf + hs) ? pol : 1 - pol;
        e.vsync      = (v >= vv + vf && v < vv + vf + vs) ? pol : 1 - pol;
        e.lineStart  = (h == 0) ? 1 : 0;
        e.frameStart = (p == 0) ? 1 : 0;
        e.frameCount = (cyc / ft) % (1 << fw);
        return e;
    endfunction

    function automatic sigT resetVals(input int pol);
        sigT e;
        e = '0;
        e.hsync = 1 - pol;
        e.vsync = 1 - pol;
        return e;
    endfunction

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s at t=%0d: got %0d, expected %0d", tag, t, observed, expected);
        end
    endtask

    task automatic compareAll(input string who, input sigT o, input sigT e);
        checkOutput({who, ".hsync"},      o.hsync,      e.hsync);
        checkOutput({who, ".vsync"},      o.vsync,      e.vsync);
        checkOutput({who, ".hblank"},     o.hblank,     e.hblank);
        checkOutput({who, ".vblank"},     o.vblank,     e.vblank);
        checkOutput({who, ".visible"},    o.visible,    e.visible);
        checkOutput({who, ".hpos"},       o.hpos,       e.hpos);
        checkOutput({who, ".vpos"},       o.vpos,       e.vpos);
        checkOutput({who, ".lineStart"},  o.lineStart,  e.lineStart);
        checkOutput({who, ".frameStart"}, o.frameStart, e.frameStart);
        checkOutput({who, ".frameCount"}, o.frameCount, e.frameCount);
    endtask

    task automatic checkResetState(input string when);
        compareAll({"A.rst.", when}, obsA, resetVals(0));
        compareAll({"B.rst.", when}, obsB, resetVals(1));
    endtask

    // Run n free-running cycles, checking both DUTs on each falling edge
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compareAll("A", obsA, modelAt(t, A_HV, A_HF, A_HS, A_HB,
                                          A_VV, A_VF, A_VS, A_VB, 0, A_FW));
            compareAll("B", obsB, modelAt(t, B_HV, B_HF, B_HS, B_HB,
                                          B_VV, B_VF, B_VS, B_VB, 1, B_FW));
            if (t < A_FT && aVisible) visibleCount++;
            t++;
        end
    endtask

    // Release reset on a falling edge so the next rising edge is cycle 0
    task automatic releaseReset();
        @(negedge clk);
        rstN = 1'b1;
        t = 0;
        visibleCount = 0;
    endtask

    // Drop reset asynchronously mid-cycle and confirm it bites before any edge
    task automatic asyncReset();
        @(posedge clk);
        #2 rstN = 1'b0;
        #1 checkResetState("async");
        @(negedge clk);
        checkResetState("held");
    endtask

    initial begin
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState("init");

        releaseReset();
        applyStimulus(5 * A_FT + 3);
        checkOutput("A.visibleCountPerFrame", visibleCount, A_HV * A_VV);

        for (int k = 0; k < 3; k++) begin
            asyncReset();
            releaseReset();
            applyStimulus(int'($urandom_range(50, 900)));
        end

        asyncReset();
        releaseReset();
        applyStimulus(A_FT + 5);
        checkOutput("A.visibleCountAfterReset", visibleCount, A_HV * A_VV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
